// File: rtl/mage_hwlp_iv_gen.sv
// mage_hwlp_iv_gen: hardware-loop iteration-variable generator (odometer over up to N_LP loops, II-paced)
// Ports: clk_i/rst_n_i clock and async active-low reset; cfg_loops_i per-loop {iv,fv,inc} (iv in MSBs);
//   cfg_n_loops_i active loop count (0 -> 1); cfg_ii_i initiation interval; start_i/abort_i control;
//   ivs_ready_i consumer ready; ivs_o/ivs_valid_o iteration vector; lp_last_o per-loop final flag;
//   busy_o not idle; done_o one-cycle completion pulse.
// Optional MAGE_HWLP_PERF_CNT_EN adds stall_cnt_o, a saturating count of stalled RUN cycles.
module mage_hwlp_iv_gen #(
  parameter int N_LP = 4,
  parameter int NBIT_LP_IV = 8,
  parameter int NBIT_II = 4,
  localparam int NBIT_N = $clog2(N_LP) + 1,
  localparam int W = NBIT_LP_IV
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_LP-1:0][3*W-1:0] cfg_loops_i,
  input  logic [NBIT_N-1:0]       cfg_n_loops_i,
  input  logic [NBIT_II-1:0]      cfg_ii_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    ivs_ready_i,
  output logic [N_LP-1:0][W-1:0]  ivs_o,
  output logic                    ivs_valid_o,
  output logic [N_LP-1:0]         lp_last_o,
  output logic                    busy_o,
  output logic                    done_o
`ifdef MAGE_HWLP_PERF_CNT_EN
  ,
  output logic [15:0]             stall_cnt_o
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;
  state_t r_state;
  logic [N_LP-1:0][W-1:0] r_iv, r_fv, r_inc, r_cur, w_nxt;
  logic [NBIT_N-1:0] r_n, w_n;
  logic [NBIT_II-1:0] r_ii, r_cnt;
  logic [N_LP-1:0] w_last;
  logic w_carry;
  logic r_valid, r_busy, r_done;
  // Last test uses one extra bit so fv at the top of the range never wraps; the carry
  // ripples upward so loop k steps only when every inner loop is on its final value.
  always_comb begin
    w_n = cfg_n_loops_i == '0 ? NBIT_N'(1) : cfg_n_loops_i > NBIT_N'(N_LP) ? NBIT_N'(N_LP) : cfg_n_loops_i;
    w_carry = 1'b1;
    for (int k = 0; k < N_LP; k++) begin
      w_last[k] = (k >= int'(r_n)) || (r_inc[k] == '0) ||
                  (({1'b0, r_cur[k]} + {1'b0, r_inc[k]}) > {1'b0, r_fv[k]});
      w_nxt[k] = !w_carry ? r_cur[k] : w_last[k] ? r_iv[k] : r_cur[k] + r_inc[k];
      w_carry = w_carry & w_last[k];
    end
  end
  assign ivs_o = r_cur;
  assign ivs_valid_o = r_valid;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign lp_last_o = r_busy ? w_last : '0;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_iv <= '0;
      r_fv <= '0;
      r_inc <= '0;
      r_cur <= '0;
      r_n <= '0;
      r_ii <= '0;
      r_cnt <= '0;
      r_valid <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (abort_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          for (int k = 0; k < N_LP; k++) begin
            r_iv[k] <= cfg_loops_i[k][3*W-1:2*W];
            r_fv[k] <= cfg_loops_i[k][2*W-1:W];
            r_inc[k] <= cfg_loops_i[k][W-1:0];
            r_cur[k] <= cfg_loops_i[k][3*W-1:2*W];
          end
          r_n <= w_n;
          r_ii <= cfg_ii_i;
          r_state <= S_RUN;
          r_valid <= 1'b1;
          r_busy <= 1'b1;
        end
        S_RUN: if (ivs_ready_i) begin
          if (&w_last) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_cur <= w_nxt;
            // Handshake cycle counts as the first of II, so wait II-1 more cycles.
            if (r_ii > NBIT_II'(1)) begin
              r_state <= S_WAIT;
              r_valid <= 1'b0;
              r_cnt <= r_ii - NBIT_II'(2);
            end
          end
        end
        S_WAIT: if (r_cnt == '0) begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt - NBIT_II'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end
`ifdef MAGE_HWLP_PERF_CNT_EN
  logic [15:0] r_stall;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_stall <= '0;
    else if (r_state == S_IDLE && start_i && !abort_i) r_stall <= '0;
    else if (r_state == S_RUN && !ivs_ready_i && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end
  assign stall_cnt_o = r_stall;
`endif
endmodule

// File: tb/tb_mage_hwlp_iv_gen.sv
// tb_mage_hwlp_iv_gen: random and directed loop nests checked against a nested-loop reference model
module tb_mage_hwlp_iv_gen;
  localparam int N_LP = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_LP-1:0][23:0] cfg_loops;
  logic [2:0] cfg_n_loops;
  logic [3:0] cfg_ii;
  logic start, abort, ready;
  logic [N_LP-1:0][7:0] ivs;
  logic ivs_valid, busy, done;
  logic [N_LP-1:0] lp_last;
`ifdef MAGE_HWLP_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mage_hwlp_iv_gen dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .cfg_loops_i(cfg_loops),
    .cfg_n_loops_i(cfg_n_loops),
    .cfg_ii_i(cfg_ii),
    .start_i(start),
    .abort_i(abort),
    .ivs_ready_i(ready),
    .ivs_o(ivs),
    .ivs_valid_o(ivs_valid),
    .lp_last_o(lp_last),
    .busy_o(busy),
    .done_o(done)
`ifdef MAGE_HWLP_PERF_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [23:0] lv(input int iv, input int fv, input int inc);
    return {8'(iv), 8'(fv), 8'(inc)};
  endfunction
  // Entered and left at #1 after a rising edge. Reference: each loop's value list is
  // iv, iv+inc, ... while <= fv; the nest is their product with loop 0 varying fastest.
  task automatic run(input int n, input int ii, input logic [N_LP-1:0][23:0] loops,
                     input bit rnd, input int abort_at);
    int vals[N_LP][$];
    int ne, total, idx, cyc, last_hs, stalls, ii_eff, budget, rem, j, v, iv, fv, inc;
    bit prev_stall;
    logic [N_LP-1:0][7:0] prev_ivs, ev;
    logic [N_LP-1:0] el;
    ne = n == 0 ? 1 : (n > N_LP ? N_LP : n);
    ii_eff = ii < 2 ? 1 : ii;
    total = 1;
    for (int k = 0; k < N_LP; k++) begin
      iv = int'(loops[k][23:16]);
      fv = int'(loops[k][15:8]);
      inc = int'(loops[k][7:0]);
      vals[k].delete();
      v = iv;
      vals[k].push_back(v);
      if (k < ne)
        while (inc != 0 && v + inc <= fv) begin
          v += inc;
          vals[k].push_back(v);
        end
      total *= vals[k].size();
    end
    budget = total * (ii_eff + 1) * 12 + 100;
    cfg_loops = loops;
    cfg_n_loops = 3'(n);
    cfg_ii = 4'(ii);
    start = 1'b1;
    ready = rnd ? 1'($urandom) : 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cfg_loops = {$urandom, $urandom, $urandom};
    cfg_n_loops = 3'($urandom);
    cfg_ii = 4'($urandom);
    @(negedge clk);
    check("first_valid", 64'(ivs_valid), 64'd1);
    idx = 0;
    cyc = 0;
    last_hs = 0;
    stalls = 0;
    prev_stall = 1'b0;
    prev_ivs = '0;
    while (idx < total && cyc < budget) begin
      check("no_early_done", 64'(done), 64'd0);
      if (prev_stall) check("hold", 64'(ivs), 64'(prev_ivs));
      if (ivs_valid && ready) begin
        rem = idx;
        for (int k = 0; k < N_LP; k++) begin
          j = rem % vals[k].size();
          rem = rem / vals[k].size();
          ev[k] = 8'(vals[k][j]);
          el[k] = (j == vals[k].size() - 1);
        end
        check("ivs", 64'(ivs), 64'(ev));
        check("lp_last", 64'(lp_last), 64'(el));
        if (idx > 0) begin
          if (rnd) check("space_min", 64'((cyc - last_hs) >= ii_eff), 64'd1);
          else check("space", 64'(cyc - last_hs), 64'(ii_eff));
        end
        last_hs = cyc;
        idx++;
      end
      prev_stall = ivs_valid && !ready;
      if (prev_stall) stalls++;
      prev_ivs = ivs;
      @(posedge clk);
      #1;
      ready = rnd ? 1'($urandom) : 1'b1;
      start = rnd && ($urandom_range(0, 7) == 0);
      if (abort_at >= 0 && idx == abort_at) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_valid", 64'(ivs_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("vec_count", 64'(idx), 64'(total));
    check("done", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd1);
`ifdef MAGE_HWLP_PERF_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(ivs_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [N_LP-1:0][23:0] l;
    int n, ii, iv;
    cfg_loops = '0;
    cfg_n_loops = '0;
    cfg_ii = '0;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ivs", 64'(ivs), 64'd0);
    check("rst_valid", 64'(ivs_valid), 64'd0);
    check("rst_last", 64'(lp_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    l = '0; l[0] = lv(0, 3, 1);
    run(1, 1, l, 0, -1);
    l = '0; l[0] = lv(0, 2, 1); l[1] = lv(4, 8, 4);
    run(2, 1, l, 0, -1);
    l = '0; l[0] = lv(0, 2, 1);
    run(1, 3, l, 0, -1);
    l = '0; l[0] = lv(250, 255, 10);
    run(1, 1, l, 0, -1);
    l = '0; l[0] = lv(5, 9, 0);
    run(1, 0, l, 0, -1);
    l = '0; l[0] = lv(9, 3, 2);
    run(1, 2, l, 0, -1);
    l = '0; l[0] = lv(0, 255, 255);
    run(1, 1, l, 0, -1);
    l = '0; l[0] = lv(1, 3, 1); l[1] = lv(10, 30, 10); l[2] = lv(7, 7, 1);
    run(3, 1, l, 0, 4);
    run(3, 1, l, 0, -1);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 64'(busy), 64'd0);
    check("start_abort_valid", 64'(ivs_valid), 64'd0);
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(0, N_LP);
      ii = $urandom_range(0, 4);
      for (int k = 0; k < N_LP; k++) begin
        iv = $urandom_range(0, 250);
        l[k] = ($urandom_range(0, 9) == 0) ? lv(iv, iv, 0) :
               ($urandom_range(0, 9) == 0) ? lv(iv + 5, iv, 3) :
               lv(iv, iv + $urandom_range(0, 12), $urandom_range(3, 6));
      end
      run(n, ii, l, 1, (t == 3) ? 2 : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
